// File: rtl/branch_resolve_ctrl.sv
// Branch resolution sequencer for the RV32I execute stage: compares operands, checks the
// fetch prediction, issues a held redirect plus a one-cycle flush, and counts outcomes.
module branch_resolve_ctrl #(
  parameter int XLEN  = 32,
  parameter int CNT_W = 16
) (
  input  logic             clk,
  input  logic             rst_n,
  input  logic             in_valid,
  output logic             in_ready,
  input  logic [2:0]       in_funct3,
  input  logic [XLEN-1:0]  in_rs1,
  input  logic [XLEN-1:0]  in_rs2,
  input  logic [XLEN-1:0]  in_pc,
  input  logic [XLEN-1:0]  in_imm,
  input  logic             in_pred_taken,
  input  logic             in_kill,
  output logic             out_valid,
  output logic             out_taken,
  output logic [XLEN-1:0]  out_target,
  output logic             out_illegal,
  output logic             redir_valid,
  input  logic             redir_ready,
  output logic [XLEN-1:0]  redir_pc,
  output logic             flush,
  input  logic             cnt_clr,
  output logic [CNT_W-1:0] cnt_branches,
  output logic [CNT_W-1:0] cnt_mispred
);

  typedef enum logic [1:0] {IDLE, EVAL, REDIR} state_e;

  state_e state_q, state_d;

  logic [2:0]             funct3_q, funct3_d;
  logic signed [XLEN-1:0] rs1_q, rs1_d;
  logic signed [XLEN-1:0] rs2_q, rs2_d;
  logic [XLEN-1:0]        pc_q, pc_d;
  logic [XLEN-1:0]        imm_q, imm_d;
  logic                   pred_q, pred_d;

  logic                   out_valid_q, out_valid_d;
  logic                   out_taken_q, out_taken_d;
  logic [XLEN-1:0]        out_target_q, out_target_d;
  logic                   out_illegal_q, out_illegal_d;
  logic [XLEN-1:0]        redir_pc_q, redir_pc_d;
  logic                   flush_q, flush_d;
  logic [CNT_W-1:0]       cnt_br_q, cnt_br_d;
  logic [CNT_W-1:0]       cnt_mp_q, cnt_mp_d;

  logic                   eq, lt, cond, illegal, taken, mispred;
  logic [XLEN-1:0]        target, fallthrough;

  function automatic logic [CNT_W-1:0] sat_inc(input logic [CNT_W-1:0] v);
    return (&v) ? v : v + CNT_W'(1);
  endfunction

  // Comparison datapath, evaluated from the captured operands during EVAL
  always_comb begin
    eq          = (rs1_q == rs2_q);
    lt          = funct3_q[1] ? ($unsigned(rs1_q) < $unsigned(rs2_q)) : (rs1_q < rs2_q);
    cond        = funct3_q[2] ? lt : eq;
    illegal     = (funct3_q[2:1] == 2'b01);
    taken       = !illegal && (cond ^ funct3_q[0]);
    mispred     = (taken != pred_q);
    target      = pc_q + imm_q;
    fallthrough = pc_q + XLEN'(4);
  end

  always_comb begin
    state_d       = state_q;
    funct3_d      = funct3_q;
    rs1_d         = rs1_q;
    rs2_d         = rs2_q;
    pc_d          = pc_q;
    imm_d         = imm_q;
    pred_d        = pred_q;
    out_valid_d   = 1'b0;
    flush_d       = 1'b0;
    out_taken_d   = out_taken_q;
    out_target_d  = out_target_q;
    out_illegal_d = out_illegal_q;
    redir_pc_d    = redir_pc_q;

    unique case (state_q)
      IDLE: begin
        if (in_valid && !in_kill) begin
          funct3_d = in_funct3;
          rs1_d    = in_rs1;
          rs2_d    = in_rs2;
          pc_d     = in_pc;
          imm_d    = in_imm;
          pred_d   = in_pred_taken;
          state_d  = EVAL;
        end
      end
      EVAL: begin
        if (in_kill) begin
          state_d = IDLE;
        end else begin
          out_valid_d   = 1'b1;
          out_taken_d   = taken;
          out_target_d  = target;
          out_illegal_d = illegal;
          if (mispred) begin
            redir_pc_d = taken ? target : fallthrough;
            flush_d    = 1'b1;
            state_d    = REDIR;
          end else begin
            state_d = IDLE;
          end
        end
      end
      REDIR: begin
        if (in_kill || redir_ready) state_d = IDLE;
      end
      default: state_d = IDLE;
    endcase
  end

  // Counters advance while the result/flush pulses are visible; clear wins
  always_comb begin
    cnt_br_d = cnt_br_q;
    cnt_mp_d = cnt_mp_q;
    if (cnt_clr) begin
      cnt_br_d = '0;
      cnt_mp_d = '0;
    end else begin
      if (out_valid_q) cnt_br_d = sat_inc(cnt_br_q);
      if (flush_q)     cnt_mp_d = sat_inc(cnt_mp_q);
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q       <= IDLE;
      out_valid_q   <= 1'b0;
      out_taken_q   <= 1'b0;
      out_target_q  <= '0;
      out_illegal_q <= 1'b0;
      redir_pc_q    <= '0;
      flush_q       <= 1'b0;
      cnt_br_q      <= '0;
      cnt_mp_q      <= '0;
    end else begin
      state_q       <= state_d;
      out_valid_q   <= out_valid_d;
      out_taken_q   <= out_taken_d;
      out_target_q  <= out_target_d;
      out_illegal_q <= out_illegal_d;
      redir_pc_q    <= redir_pc_d;
      flush_q       <= flush_d;
      cnt_br_q      <= cnt_br_d;
      cnt_mp_q      <= cnt_mp_d;
    end
  end

  // Operand capture registers carry data only and need no reset
  always_ff @(posedge clk) begin
    funct3_q <= funct3_d;
    rs1_q    <= rs1_d;
    rs2_q    <= rs2_d;
    pc_q     <= pc_d;
    imm_q    <= imm_d;
    pred_q   <= pred_d;
  end

  assign in_ready     = (state_q == IDLE);
  assign redir_valid  = (state_q == REDIR);
  assign out_valid    = out_valid_q;
  assign out_taken    = out_taken_q;
  assign out_target   = out_target_q;
  assign out_illegal  = out_illegal_q;
  assign redir_pc     = redir_pc_q;
  assign flush        = flush_q;
  assign cnt_branches = cnt_br_q;
  assign cnt_mispred  = cnt_mp_q;

endmodule

// File: tb/tb_branch_resolve_ctrl.sv
// Scoreboard bench for branch_resolve_ctrl: a driver pushes model results, a monitor pops
// them whenever out_valid is seen; a narrow counter width keeps saturation reachable.
module tb_branch_resolve_ctrl;
  localparam int XLEN  = 32;
  localparam int CNT_W = 5;
  localparam logic [CNT_W-1:0] CMAX = '1;

  logic             clk = 1'b0;
  logic             rst_n;
  logic             in_valid, in_ready, in_pred_taken, in_kill;
  logic [2:0]       in_funct3;
  logic [XLEN-1:0]  in_rs1, in_rs2, in_pc, in_imm;
  logic             out_valid, out_taken, out_illegal;
  logic [XLEN-1:0]  out_target, redir_pc;
  logic             redir_valid, redir_ready, flush, cnt_clr;
  logic [CNT_W-1:0] cnt_branches, cnt_mispred;

  branch_resolve_ctrl #(.XLEN(XLEN), .CNT_W(CNT_W)) dut (
    .clk(clk), .rst_n(rst_n),
    .in_valid(in_valid), .in_ready(in_ready), .in_funct3(in_funct3),
    .in_rs1(in_rs1), .in_rs2(in_rs2), .in_pc(in_pc), .in_imm(in_imm),
    .in_pred_taken(in_pred_taken), .in_kill(in_kill),
    .out_valid(out_valid), .out_taken(out_taken), .out_target(out_target),
    .out_illegal(out_illegal), .redir_valid(redir_valid), .redir_ready(redir_ready),
    .redir_pc(redir_pc), .flush(flush), .cnt_clr(cnt_clr),
    .cnt_branches(cnt_branches), .cnt_mispred(cnt_mispred)
  );

  always #5 clk = ~clk;

  typedef struct {
    logic            taken;
    logic [XLEN-1:0] target;
    logic            ill;
    logic            mis;
    logic [XLEN-1:0] rpc;
  } exp_t;

  exp_t sb_q[$];
  int n_tests = 0;
  int n_fail  = 0;
  int exp_br  = 0;
  int exp_mp  = 0;

  task automatic chk(input string name, input logic [63:0] act, input logic [63:0] exp);
    n_tests++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got 0x%0h, expected 0x%0h", name, act, exp);
    end
  endtask

  function automatic exp_t model(input logic [2:0] f3, input logic [XLEN-1:0] a, b, pc, imm,
                                 input logic pred);
    exp_t e;
    int signed sa, sb;
    longint unsigned sum;
    sa = a;
    sb = b;
    e.ill = 1'b0;
    case (f3)
      3'd0:    e.taken = (a == b);
      3'd1:    e.taken = (a != b);
      3'd4:    e.taken = (sa < sb);
      3'd5:    e.taken = (sa >= sb);
      3'd6:    e.taken = (a < b);
      3'd7:    e.taken = (a >= b);
      default: begin e.taken = 1'b0; e.ill = 1'b1; end
    endcase
    sum      = (longint'(pc) + longint'(imm)) % 64'h1_0000_0000;
    e.target = sum[XLEN-1:0];
    e.mis    = (e.taken != pred);
    sum      = (longint'(pc) + 64'd4) % 64'h1_0000_0000;
    e.rpc    = e.taken ? e.target : sum[XLEN-1:0];
    return e;
  endfunction

  function automatic int sat(input int v);
    return (v >= int'(CMAX)) ? int'(CMAX) : v + 1;
  endfunction

  // Monitor: every result pulse must match the oldest outstanding expectation
  always @(negedge clk) begin
    if (rst_n) begin
      if (out_valid) begin
        if (sb_q.size() == 0) begin
          chk("unexpected_out_valid", 1, 0);
        end else begin
          exp_t e;
          e = sb_q.pop_front();
          chk("out_taken", out_taken, e.taken);
          chk("out_target", out_target, e.target);
          chk("out_illegal", out_illegal, e.ill);
          chk("flush_with_valid", flush, e.mis);
          chk("redir_valid_with_valid", redir_valid, e.mis);
          if (e.mis) chk("redir_pc", redir_pc, e.rpc);
        end
      end else if (flush) begin
        chk("flush_without_valid", 1, 0);
      end
    end
  end

  // mode: 0 normal, 1 kill in EVAL, 2 kill in REDIR, 3 clear counters at result, 4 kill at accept
  task automatic do_branch(input logic [2:0] f3, input logic [XLEN-1:0] a, b, pc, imm,
                           input logic pred, input int mode, input int wait_n);
    exp_t e;
    @(negedge clk);
    chk("in_ready_idle", in_ready, 1);
    in_valid = 1'b1; in_funct3 = f3; in_rs1 = a; in_rs2 = b;
    in_pc = pc; in_imm = imm; in_pred_taken = pred;
    in_kill = (mode == 4);
    @(posedge clk);
    #1 in_valid = 1'b0; in_kill = 1'b0;
    @(negedge clk);
    if (mode == 4) begin
      chk("kill_blocks_capture", in_ready, 1);
      @(negedge clk);
      chk("kill_accept_no_valid", out_valid, 0);
      return;
    end
    chk("in_ready_eval", in_ready, 0);
    chk("valid_lat1", out_valid, 0);
    e = model(f3, a, b, pc, imm, pred);
    if (mode == 1) begin
      in_kill = 1'b1;
      @(posedge clk);
      #1 in_kill = 1'b0;
      @(negedge clk);
      chk("kill_eval_valid", out_valid, 0);
      chk("kill_eval_flush", flush, 0);
      chk("kill_eval_redir", redir_valid, 0);
      chk("kill_eval_idle", in_ready, 1);
      return;
    end
    sb_q.push_back(e);
    if (mode == 3) begin
      exp_br = 0;
      exp_mp = 0;
    end else begin
      exp_br = sat(exp_br);
      if (e.mis) exp_mp = sat(exp_mp);
    end
    @(negedge clk);
    chk("valid_lat2", out_valid, 1);
    if (mode == 3) begin
      cnt_clr = 1'b1;
      @(posedge clk);
      #1 cnt_clr = 1'b0;
      @(negedge clk);
    end
    if (!e.mis) begin
      chk("no_mis_idle", in_ready, 1);
      chk("no_mis_redir", redir_valid, 0);
      return;
    end
    repeat (wait_n) begin
      chk("redir_hold_valid", redir_valid, 1);
      chk("redir_hold_pc", redir_pc, e.rpc);
      chk("redir_hold_ready", in_ready, 0);
      @(negedge clk);
    end
    redir_ready = 1'b1;
    in_kill = (mode == 2);
    @(posedge clk);
    #1 redir_ready = 1'b0; in_kill = 1'b0;
    @(negedge clk);
    chk("redir_drop", redir_valid, 0);
    chk("redir_idle", in_ready, 1);
    chk("flush_one_cycle", flush, 0);
  endtask

  task automatic chk_cnt();
    @(negedge clk);
    chk("cnt_branches", cnt_branches, exp_br[CNT_W-1:0]);
    chk("cnt_mispred", cnt_mispred, exp_mp[CNT_W-1:0]);
  endtask

  initial begin
    #200000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog");
  end

  initial begin
    logic [2:0] f3s [8];
    f3s = '{3'd0, 3'd1, 3'd4, 3'd5, 3'd6, 3'd7, 3'd2, 3'd3};
    rst_n = 1'b0; in_valid = 1'b0; in_kill = 1'b0; redir_ready = 1'b0; cnt_clr = 1'b0;
    in_funct3 = '0; in_rs1 = '0; in_rs2 = '0; in_pc = '0; in_imm = '0; in_pred_taken = 1'b0;
    #12;
    chk("rst_in_ready", in_ready, 1);
    chk("rst_out_valid", out_valid, 0);
    chk("rst_redir_valid", redir_valid, 0);
    chk("rst_flush", flush, 0);
    chk("rst_out_target", out_target, 0);
    chk("rst_redir_pc", redir_pc, 0);
    chk("rst_cnt_br", cnt_branches, 0);
    chk("rst_cnt_mp", cnt_mispred, 0);
    @(negedge clk);
    rst_n = 1'b1;

    do_branch(3'd0, 32'd5, 32'd5, 32'h100, 32'h20, 1'b1, 0, 0);
    chk_cnt();
    chk("first_branch_count", cnt_branches, 1);
    do_branch(3'd4, 32'hFFFF_FFFF, 32'd1, 32'h300, 32'h40, 1'b0, 0, 1);
    chk_cnt();
    do_branch(3'd6, 32'hFFFF_FFFF, 32'd1, 32'h300, 32'h40, 1'b0, 0, 0);
    chk_cnt();
    do_branch(3'd1, 32'd7, 32'd7, 32'h200, 32'h80, 1'b1, 0, 3);
    chk_cnt();
    do_branch(3'd0, 32'd9, 32'd9, 32'h400, 32'h10, 1'b0, 1, 0);
    chk_cnt();
    do_branch(3'd1, 32'd7, 32'd7, 32'h500, 32'h10, 1'b1, 2, 1);
    chk_cnt();
    do_branch(3'd2, 32'd1, 32'd1, 32'h600, 32'h10, 1'b0, 0, 0);
    do_branch(3'd3, 32'd1, 32'd2, 32'h700, 32'h10, 1'b1, 0, 0);
    do_branch(3'd0, 32'd1, 32'd1, 32'hFFFF_FFFC, 32'd8, 1'b1, 0, 0);
    do_branch(3'd0, 32'd3, 32'd3, 32'h800, 32'h4, 1'b1, 4, 0);
    chk_cnt();

    for (int i = 0; i < 80; i++) begin
      logic [XLEN-1:0] a, b;
      int r, mode;
      a = $urandom();
      b = ($urandom_range(0, 3) == 0) ? a : $urandom();
      if ($urandom_range(0, 3) == 0) begin a = $urandom_range(0, 3); b = $urandom_range(0, 3); end
      r = $urandom_range(0, 9);
      mode = (r < 5) ? r : 0;
      if (mode == 0 && r > 4) mode = 0;
      do_branch(f3s[$urandom_range(0, 7)], a, b, $urandom(), $urandom(), 1'($urandom_range(0, 1)),
                (r >= 1 && r <= 4) ? r : 0, $urandom_range(0, 3));
      chk_cnt();
    end

    for (int i = 0; i < 40; i++) do_branch(3'd1, 32'd7, 32'd7, 32'h900, 32'h8, 1'b1, 0, 0);
    chk_cnt();
    chk("sat_branches", cnt_branches, CMAX);
    chk("sat_mispred", cnt_mispred, CMAX);

    do_branch(3'd0, 32'd1, 32'd2, 32'hA00, 32'h8, 1'b1, 3, 1);
    chk_cnt();
    chk("clr_branches", cnt_branches, 0);
    chk("clr_mispred", cnt_mispred, 0);

    // Reset asserted while a redirect is pending
    @(negedge clk);
    in_valid = 1'b1; in_funct3 = 3'd1; in_rs1 = 32'd7; in_rs2 = 32'd7;
    in_pc = 32'hB00; in_imm = 32'h10; in_pred_taken = 1'b1;
    @(posedge clk);
    #1 in_valid = 1'b0;
    sb_q.push_back(model(3'd1, 32'd7, 32'd7, 32'hB00, 32'h10, 1'b1));
    @(negedge clk);
    @(negedge clk);
    chk("pre_reset_redir", redir_valid, 1);
    #2 rst_n = 1'b0;
    #1;
    chk("reset_redir_valid", redir_valid, 0);
    chk("reset_in_ready", in_ready, 1);
    chk("reset_out_valid", out_valid, 0);
    chk("reset_redir_pc", redir_pc, 0);
    chk("reset_cnt_br", cnt_branches, 0);
    chk("reset_cnt_mp", cnt_mispred, 0);
    @(negedge clk);
    rst_n = 1'b1;
    @(negedge clk);
    chk("sb_empty", sb_q.size(), 0);

    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end
endmodule

// File: doc/branch_resolve_ctrl.md
Name: branch_resolve_ctrl

Overview:
- Sequences branch resolution for the RV32I execute stage.
- Accepts one conditional branch at a time over a valid/ready handshake and decodes funct3 into an equal/less-than, signed/unsigned comparison.
- Computes the taken decision and target, and checks the decision against the fetch-stage prediction.
- On mispredict, drives a held fetch redirect plus a one-cycle pipeline flush.
- Keeps saturating branch and mispredict counters for performance monitoring.

Parameters:
XLEN, 32, datapath width of operands, PC and immediate
CNT_W, 16, width of each performance counter

Ports:
clk  in  1  system clock, rising edge
rst_n  in  1  asynchronous active-low reset
in_valid  in  1  branch operands valid
in_ready  out  1  block can accept a branch
in_funct3  in  3  branch funct3 (000 beq, 001 bne, 100 blt, 101 bge, 110 bltu, 111 bgeu)
in_rs1  in  XLEN  first operand
in_rs2  in  XLEN  second operand
in_pc  in  XLEN  branch instruction PC
in_imm  in  XLEN  sign-extended B-immediate
in_pred_taken  in  1  fetch prediction for this branch
in_kill  in  1  older-instruction flush; aborts any in-flight branch
out_valid  out  1  one-cycle pulse: resolution result valid
out_taken  out  1  resolved direction
out_target  out  XLEN  pc+imm
out_illegal  out  1  funct3 was 010 or 011
redir_valid  out  1  fetch redirect request
redir_ready  in  1  fetch accepts redirect
redir_pc  out  XLEN  redirect address
flush  out  1  one-cycle flush of younger instructions
cnt_clr  in  1  synchronous clear of both counters
cnt_branches  out  CNT_W  resolved-branch count
cnt_mispred  out  CNT_W  mispredict count

Behaviour:
- Reset values: state IDLE; in_ready=1; out_valid, out_taken, out_illegal, redir_valid and flush = 0; out_target, redir_pc and both counters = 0.
- FSM states: IDLE, EVAL, REDIR.
- IDLE:
  - in_ready=1.
  - On in_valid&in_ready: capture funct3, rs1, rs2, pc, imm and pred_taken into registers, then go to EVAL.
  - in_kill in the same cycle blocks capture.
- EVAL:
  - in_ready=0; one cycle.
  - eq = rs1==rs2; lt = signed or unsigned less-than, with funct3[1] selecting unsigned.
  - Condition: funct3[2]=0 gives eq; funct3[2]=1 gives lt. funct3[0] inverts the condition.
  - funct3 010/011 are illegal: taken=0 and out_illegal=1.
  - target = pc+imm, modulo 2^XLEN with carry discarded; fallthrough = pc+4, modulo 2^XLEN.
  - mispredict = taken != pred_taken.
  - At the closing edge: register out_taken, out_target and out_illegal, and pulse out_valid for the following cycle.
  - If mispredict: redir_pc = taken ? target : fallthrough, set redir_valid, pulse flush for one cycle, go to REDIR.
  - Else go to IDLE.
- REDIR:
  - redir_valid=1; redir_pc is held stable.
  - On redir_ready go to IDLE, and redir_valid drops in the next cycle.
  - in_ready=0 throughout.
- Timing:
  - Acceptance to out_valid latency is 2 cycles.
  - Throughput is one branch per 2 cycles when there is no mispredict.
  - out_valid and flush coincide on a mispredict.
- in_kill:
  - In EVAL: suppress out_valid, flush, redirect and counter updates; go to IDLE.
  - In REDIR: drop redir_valid next cycle; go to IDLE.
  - in_kill has priority over redir_ready.
- Counters:
  - cnt_branches increments on every out_valid pulse; cnt_mispred increments on every flush pulse.
  - Both saturate at all-ones.
  - cnt_clr has priority over increment in the same cycle.
- Reset asserted mid-operation returns the block to IDLE immediately with all outputs at their reset values; pending redirects are dropped.

Test Plan:
- beq rs1=5, rs2=5, pc=0x100, imm=0x20, pred=1 -> out_valid 2 cycles after accept, taken=1, target=0x120; no flush or redirect; cnt_branches=1.
- blt rs1=0xFFFFFFFF, rs2=1, pred=0 -> taken=1 (signed), flush pulse, redir_pc=pc+imm. bltu with the same operands -> taken=0, no redirect.
- bne rs1=rs2=7, pred=1, pc=0x200 -> taken=0, redir_pc=0x204. Hold redir_ready=0 for 3 cycles -> redir_valid and redir_pc stable and in_ready=0; then redir_ready=1 -> IDLE.
- in_kill asserted during EVAL -> no out_valid and no counter change. in_kill in REDIR together with redir_ready -> redirect dropped, IDLE next cycle.
- funct3=010 -> out_illegal=1, taken=0. pc=0xFFFFFFFC, imm=8 -> target=0x4 (wrap).
- Preload counters to 0xFFFF via repeated mispredicts -> both hold at 0xFFFF. cnt_clr on the same cycle as an increment -> counters read 0. rst_n low mid-REDIR -> redir_valid=0 immediately.
